avalanche_collector: RTL and testbench
======================================

# avalanche_collector

Entropy collector for the Cryptech avalanche noise board. It synchronizes the raw `ct_noise` pin into `sys_clk` and turns noise edges into random bits by sampling a free-running phase toggle. It packs the bits into 32-bit words and buffers them in a FIFO. It is a register-mapped core on the `sys_clk` side of the EIM arbiter: `eim_memory` selects it as one segment and reads it through the standard core bus. It also drives `ct_led`.

## Interface
- `FIFO_AW`, 3 — FIFO address width; depth = 2^FIFO_AW words; legal range 1..7.
- `sys_clk`  in  1  system clock; the only clock.
- `sys_rst`  in  1  reset; synchronous, active-high.
- `noise`  in  1  raw avalanche noise from the pin; asynchronous.
- `cs`  in  1  core select from `eim_memory`; one-cycle strobe per access.
- `we`  in  1  write enable; qualified by `cs`.
- `address`  in  8  register address.
- `write_data`  in  32  write data.
- `read_data`  out  32  registered read data.
- `led`  out  8  bits [7:0] of the most recently completed word.

## Operation
- Synchronizer: 2 flops (`n1`, `n2`), then an edge flop `n3`. A rising edge is detected when `n2 & ~n3`.
- Phase: 1-bit `ph`. Reset value is 0. It toggles every cycle while `CTRL.enable=1` and holds while disabled.
- Raw bit: the value of `ph` in the cycle a rising edge is detected. It is accepted only while enabled.
- Packer: 32-bit shift register with a 5-bit count.
  - Each accepted bit shifts in at the LSB.
  - When the 32nd bit is accepted, the word `{shift[30:0],bit}` is pushed to the FIFO and `led` is updated with its bits [7:0], both on that same edge. The count returns to 0.
- FIFO full on push: the word is dropped, `STATUS.overflow` is set (sticky), and `led` is still updated.
- Pop and push in the same cycle while full: the pop frees an entry and the push is accepted. No overflow is flagged.
- Clearing `CTRL.enable` (1→0): the partial word and count are cleared. FIFO contents and `led` are retained.
- Register map (reads of unlisted addresses return 0; writes to them are ignored):
  - 0x00 NAME0 = 0x61766C61 ("avla"), 0x01 NAME1 = 0x6E636865 ("nche"), 0x02 VERSION = 0x302E3130 ("0.10").
  - 0x08 CTRL: bit0 `enable`, R/W, resets to 0.
  - 0x09 STATUS: bit0 `valid` (FIFO not empty); bit1 `overflow` (writing 1 to bit1 clears it); bits[15:8] FIFO occupancy.
  - 0x0A DATA: returns the FIFO head and pops it. If the FIFO is empty it returns 0, does not pop, and changes no state.
  - 0x0B EDGES: 32-bit count of detected rising edges while enabled; wraps at 2^32; any write clears it.

## Timing
- All outputs reset to 0: `read_data`, `led`. Reset also clears FIFO pointers, occupancy, `overflow`, `enable`, `ph`, the packer and EDGES.
- Read latency is one cycle: `read_data` is valid on the edge after the `cs & ~we` cycle and holds until the next read.
- The pop happens on the same edge that registers `read_data`.
- STATUS read in the same cycle as a push or pop reflects the pre-edge state.
- Noise-to-bit latency: 3 cycles from a pin rise to the edge-detect cycle.
  - Pulses narrower than one `sys_clk` period may be lost. This is accepted.
- Write with overflow set coincident with a push that overflows: set wins.
- `sys_rst` mid-word or mid-read: everything returns to its reset value on that edge, and no pop is performed.

## Configuration
- `AVALANCHE_DEBIAS_EN`, defined: raw bits are von Neumann debiased.
  - Raw bits are taken in non-overlapping pairs: 01→0, 10→1, 00/11 discarded. Only output bits enter the packer.
  - The pair state clears with the partial word.
  - EDGES still counts every edge.
- Not defined: every raw bit enters the packer directly.

## Test plan
- Reset, then read 0x00/0x01/0x02/0x08/0x09 → 0x61766C61, 0x6E636865, 0x302E3130, 0, 0; `led`=0.
- Raw build, enable, 32 noise rises spaced exactly 10 cycles → exactly one word, 0x00000000 or 0xFFFFFFFF; STATUS=0x00000101; EDGES=32; DATA read returns the word, then STATUS=0.
- Raw build, FIFO_AW=3, 9×32 evenly spaced rises with no reads → occupancy 8, overflow=1; write 0x2 to 0x09 → overflow=0, occupancy 8.
- Read DATA when empty → 0, occupancy stays 0, no state change. Pop while a push completes with the FIFO full → occupancy stays 8, overflow stays 0.
- Debias build, 64 rises spaced 10 cycles → no word (all pairs equal). Rises alternating 9/10-cycle spacing → pairs differ, one word per 64 rises.
- Disable after 20 bits, re-enable, 32 rises → exactly one word containing only post-re-enable bits; EDGES=52.

Source files
------------

// File: rtl/avalanche_collector.sv
// avalanche_collector: entropy collector for the Cryptech avalanche noise board.
// Synchronizes the raw noise pin and samples a free-running phase toggle on each
// rising noise edge. The resulting bits are packed into 32-bit words and buffered
// in a FIFO that is read through a register-mapped core bus.
// Optional feature: define AVALANCHE_DEBIAS_EN to apply von Neumann debiasing
// to the raw bits before they reach the packer.
module avalanche_collector #(
  parameter int FIFO_AW = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        noise,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  led
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   OCC_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   OCC_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  localparam logic [7:0] ADDR_NAME0   = 8'h00;
  localparam logic [7:0] ADDR_NAME1   = 8'h01;
  localparam logic [7:0] ADDR_VERSION = 8'h02;
  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_DATA    = 8'h0A;
  localparam logic [7:0] ADDR_EDGES   = 8'h0B;

  logic n1_q, n1_d, n2_q, n2_d, n3_q, n3_d;
  logic ph_q, ph_d;
  logic enable_q, enable_d;
  logic [31:0] shift_q, shift_d;
  logic [4:0]  count_q, count_d;
  logic [FIFO_AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [FIFO_AW:0]   occ_q, occ_d;
  logic overflow_q, overflow_d;
  logic [31:0] edges_q, edges_d;
  logic [31:0] readData_q, readData_d;
  logic [7:0]  led_q, led_d;
`ifdef AVALANCHE_DEBIAS_EN
  logic pairValid_q, pairValid_d, pairFirst_q, pairFirst_d;
`endif

  logic [31:0] mem [DEPTH];

  logic edgeAcc, bitValid, bitVal, wordDone;
  logic rdStrobe, wrStrobe, fifoEmpty, fifoFull, pop, pushOk, pushDrop;
  logic [31:0] newWord, readMux;

  // Next-state logic for the synchronizer, phase, packer, FIFO bookkeeping and registers
  always_comb begin
    n1_d       = noise;
    n2_d       = n1_q;
    n3_d       = n2_q;
    ph_d       = ph_q;
    enable_d   = enable_q;
    shift_d    = shift_q;
    count_d    = count_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    occ_d      = occ_q;
    overflow_d = overflow_q;
    edges_d    = edges_q;
    readData_d = readData_q;
    led_d      = led_q;
    readMux    = 32'h0;

    rdStrobe  = cs & ~we;
    wrStrobe  = cs & we;
    edgeAcc   = n2_q & ~n3_q & enable_q;
    fifoEmpty = (occ_q == '0);
    fifoFull  = (occ_q == OCC_FULL);

`ifdef AVALANCHE_DEBIAS_EN
    pairValid_d = pairValid_q;
    pairFirst_d = pairFirst_q;
    bitValid    = edgeAcc & pairValid_q & (pairFirst_q != ph_q);
    bitVal      = pairFirst_q;
`else
    bitValid    = edgeAcc;
    bitVal      = ph_q;
`endif

    wordDone = bitValid & (count_q == 5'd31);
    newWord  = {shift_q[30:0], bitVal};

    pop      = rdStrobe & (address == ADDR_DATA) & ~fifoEmpty;
    pushOk   = wordDone & (~fifoFull | pop);
    pushDrop = wordDone & fifoFull & ~pop;

    if (enable_q) begin
      ph_d = ~ph_q;
    end

    if (wrStrobe && address == ADDR_CTRL) begin
      enable_d = write_data[0];
    end

    if (!enable_q) begin
      shift_d = 32'h0;
      count_d = 5'd0;
`ifdef AVALANCHE_DEBIAS_EN
      pairValid_d = 1'b0;
      pairFirst_d = 1'b0;
`endif
    end else begin
`ifdef AVALANCHE_DEBIAS_EN
      if (edgeAcc) begin
        pairValid_d = ~pairValid_q;
        pairFirst_d = ph_q;
      end
`endif
      if (bitValid) begin
        shift_d = newWord;
        count_d = count_q + 5'd1;
      end
    end

    if (wordDone) begin
      led_d = newWord[7:0];
    end

    if (pushOk) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
    case ({pushOk, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase

    if (pushDrop) begin
      overflow_d = 1'b1;
    end else if (wrStrobe && address == ADDR_STATUS && write_data[1]) begin
      overflow_d = 1'b0;
    end

    if (wrStrobe && address == ADDR_EDGES) begin
      edges_d = 32'h0;
    end else if (edgeAcc) begin
      edges_d = edges_q + 32'd1;
    end

    case (address)
      ADDR_NAME0:   readMux = 32'h61766C61;
      ADDR_NAME1:   readMux = 32'h6E636865;
      ADDR_VERSION: readMux = 32'h302E3130;
      ADDR_CTRL:    readMux = {31'h0, enable_q};
      ADDR_STATUS:  readMux = {16'h0, 8'(occ_q), 6'h0, overflow_q, ~fifoEmpty};
      ADDR_DATA:    readMux = fifoEmpty ? 32'h0 : mem[rdPtr_q];
      ADDR_EDGES:   readMux = edges_q;
      default:      readMux = 32'h0;
    endcase

    if (rdStrobe) begin
      readData_d = readMux;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      n1_q       <= 1'b0;
      n2_q       <= 1'b0;
      n3_q       <= 1'b0;
      ph_q       <= 1'b0;
      enable_q   <= 1'b0;
      shift_q    <= 32'h0;
      count_q    <= 5'd0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
      edges_q    <= 32'h0;
      readData_q <= 32'h0;
      led_q      <= 8'h0;
`ifdef AVALANCHE_DEBIAS_EN
      pairValid_q <= 1'b0;
      pairFirst_q <= 1'b0;
`endif
    end else begin
      n1_q       <= n1_d;
      n2_q       <= n2_d;
      n3_q       <= n3_d;
      ph_q       <= ph_d;
      enable_q   <= enable_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
      edges_q    <= edges_d;
      readData_q <= readData_d;
      led_q      <= led_d;
`ifdef AVALANCHE_DEBIAS_EN
      pairValid_q <= pairValid_d;
      pairFirst_q <= pairFirst_d;
`endif
    end
  end

  // FIFO storage; contents need no reset because pointers and occupancy gate every read
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && pushOk) begin
      mem[wrPtr_q] <= newWord;
    end
  end

  assign read_data = readData_q;
  assign led       = led_q;

endmodule

// File: tb/tb_avalanche_collector.sv
// tb_avalanche_collector: scoreboard bench for avalanche_collector.
// Bus reads push their expected value into a queue; a monitor compares
// read_data one cycle after each read strobe. A small behavioural model of the
// phase toggle, packer and FIFO supplies expected words and status.
module tb_avalanche_collector;

  localparam int FIFO_AW = 3;
  localparam int DEPTH   = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        noise = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  address = 8'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic [7:0]  led;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] expQ[$];
  string       nameQ[$];
  logic        rdPending = 1'b0;

  bit          tbEn = 1'b0;
  logic        phModel = 1'b0;
  logic [31:0] mShift = 32'h0;
  int          mCount = 0;
  logic [31:0] mFifo[$];
  logic        mOverflow = 1'b0;
  logic [7:0]  mLed = 8'h0;
  logic [31:0] mEdges = 32'h0;
  bit          mPairValid = 1'b0;
  logic        mPairFirst = 1'b0;

  avalanche_collector #(.FIFO_AW(FIFO_AW)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .noise      (noise),
    .cs         (cs),
    .we         (we),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .led        (led)
  );

  always #5 sys_clk = ~sys_clk;

  // Phase model: toggles every cycle while the core is enabled
  always @(posedge sys_clk) begin
    if (sys_rst) phModel <= 1'b0;
    else if (tbEn) phModel <= ~phModel;
  end

  // Marks cycles whose read strobe makes read_data valid after the edge
  always @(posedge sys_clk) begin
    rdPending <= cs & ~we & ~sys_rst;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares each registered read against the oldest expectation
  always @(negedge sys_clk) begin
    if (rdPending) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected read", 32'h1, 32'h0);
      end else begin
        checkOutput(nameQ.pop_front(), read_data, expQ.pop_front());
      end
    end
  end

  function automatic void clearPacker();
    mShift     = 32'h0;
    mCount     = 0;
    mPairValid = 1'b0;
    mPairFirst = 1'b0;
  endfunction

  function automatic void acceptBit(input logic rawBit);
    logic b;
    b = rawBit;
`ifdef AVALANCHE_DEBIAS_EN
    if (!mPairValid) begin
      mPairValid = 1'b1;
      mPairFirst = rawBit;
      return;
    end
    mPairValid = 1'b0;
    if (mPairFirst == rawBit) return;
    b = mPairFirst;
`endif
    mShift = {mShift[30:0], b};
    mCount++;
    if (mCount == 32) begin
      mCount = 0;
      mLed   = mShift[7:0];
      if (mFifo.size() < DEPTH) mFifo.push_back(mShift);
      else mOverflow = 1'b1;
    end
  endfunction

  function automatic logic [31:0] expectRead(input logic [7:0] addr);
    case (addr)
      8'h00:   return 32'h61766C61;
      8'h01:   return 32'h6E636865;
      8'h02:   return 32'h302E3130;
      8'h08:   return {31'h0, tbEn};
      8'h09:   return {16'h0, 8'(mFifo.size()), 6'h0, mOverflow, mFifo.size() != 0};
      8'h0A:   return (mFifo.size() != 0) ? mFifo.pop_front() : 32'h0;
      8'h0B:   return mEdges;
      default: return 32'h0;
    endcase
  endfunction

  task automatic doReset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    cs = 1'b0; we = 1'b0; noise = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    tbEn = 1'b0;
    clearPacker();
    mFifo.delete();
    mOverflow = 1'b0;
    mLed = 8'h0;
    mEdges = 32'h0;
  endtask

  task automatic readReg(input logic [7:0] addr, input string name);
    @(negedge sys_clk);
    cs = 1'b1; we = 1'b0; address = addr;
    expQ.push_back(expectRead(addr));
    nameQ.push_back(name);
    @(negedge sys_clk);
    cs = 1'b0;
  endtask

  task automatic writeReg(input logic [7:0] addr, input logic [31:0] data);
    @(negedge sys_clk);
    cs = 1'b1; we = 1'b1; address = addr; write_data = data;
    @(negedge sys_clk);
    cs = 1'b0; we = 1'b0;
    case (addr)
      8'h08: begin
        tbEn = data[0];
        if (!data[0]) clearPacker();
      end
      8'h09: if (data[1]) mOverflow = 1'b0;
      8'h0B: mEdges = 32'h0;
      default: ;
    endcase
  endtask

  // One noise rise held 3 cycles; the next call starts 'spacing' cycles later
  task automatic riseNoise(input int spacing, input bit popAtPush);
    @(negedge sys_clk);
    noise = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    if (popAtPush) begin
      cs = 1'b1; we = 1'b0; address = 8'h0A;
      expQ.push_back(expectRead(8'h0A));
      nameQ.push_back("DATA pop while full");
    end
    if (tbEn) begin
      mEdges++;
      acceptBit(phModel);
    end
    @(negedge sys_clk);
    noise = 1'b0;
    cs = 1'b0;
    repeat (spacing - 4) @(negedge sys_clk);
  endtask

  task automatic applyStimulus();
    // Reset values and identification registers
    doReset();
    readReg(8'h00, "NAME0");
    readReg(8'h01, "NAME1");
    readReg(8'h02, "VERSION");
    readReg(8'h08, "CTRL reset");
    readReg(8'h09, "STATUS reset");
    readReg(8'h05, "unlisted addr");
    checkOutput("led reset", {24'h0, led}, 32'h0);
    readReg(8'h0A, "DATA empty");
    readReg(8'h09, "STATUS after empty read");

`ifdef AVALANCHE_DEBIAS_EN
    writeReg(8'h08, 32'h1);
    for (int i = 0; i < 64; i++) riseNoise(10, 1'b0);
    readReg(8'h09, "STATUS equal pairs");
    readReg(8'h0B, "EDGES equal pairs");
    for (int i = 0; i < 64; i++) riseNoise((i % 2 == 0) ? 9 : 10, 1'b0);
    readReg(8'h09, "STATUS unequal pairs");
    readReg(8'h0A, "DATA debiased word");
    readReg(8'h0B, "EDGES total");
    checkOutput("led debiased", {24'h0, led}, {24'h0, mLed});
`else
    // One full word from evenly spaced rises
    writeReg(8'h08, 32'h1);
    readReg(8'h08, "CTRL enabled");
    for (int i = 0; i < 32; i++) riseNoise(10, 1'b0);
    readReg(8'h09, "STATUS one word");
    readReg(8'h0B, "EDGES 32");
    checkOutput("led one word", {24'h0, led}, {24'h0, mLed});
    readReg(8'h0A, "DATA one word");
    readReg(8'h09, "STATUS drained");

    // Fill past capacity; odd gap after each word flips the next word's polarity
    doReset();
    writeReg(8'h08, 32'h1);
    for (int i = 0; i < 9 * 32; i++) riseNoise((i % 32 == 31) ? 11 : 10, 1'b0);
    readReg(8'h09, "STATUS overflowed");
    writeReg(8'h09, 32'h2);
    readReg(8'h09, "STATUS overflow cleared");
    for (int i = 0; i < 32; i++) riseNoise((i % 32 == 31) ? 11 : 10, i == 31);
    readReg(8'h09, "STATUS after pop+push full");
    checkOutput("led after overflow", {24'h0, led}, {24'h0, mLed});
    for (int i = 0; i < DEPTH; i++) readReg(8'h0A, $sformatf("DATA drain %0d", i));
    readReg(8'h09, "STATUS after drain");
    writeReg(8'h0B, 32'h0);
    readReg(8'h0B, "EDGES cleared");

    // Disable mid-word discards the partial word
    doReset();
    writeReg(8'h08, 32'h1);
    for (int i = 0; i < 20; i++) riseNoise(9, 1'b0);
    writeReg(8'h08, 32'h0);
    writeReg(8'h08, 32'h1);
    for (int i = 0; i < 32; i++) riseNoise(10, 1'b0);
    readReg(8'h09, "STATUS after re-enable");
    readReg(8'h0B, "EDGES 52");
    readReg(8'h0A, "DATA post re-enable");
    checkOutput("led post re-enable", {24'h0, led}, {24'h0, mLed});
`endif
  endtask

  initial begin
    applyStimulus();
    repeat (4) @(negedge sys_clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: timeout reached, compared %0d", compared);
    $fatal(1, "[TB] timeout");
  end

endmodule
